inst_fetch: RTL

- Instruction fetch stage that sits directly upstream of the 16-bit instruction memory.
- Owns the word-addressed PC and drives the memory's 32-bit address each cycle.
- Captures the 16-bit q one cycle later and presents {instruction, PC} to decode over a valid/ready handshake.
- Handles branch redirects, downstream back-pressure (one-entry skid buffer), the 64K-word block-switch hazard of the memory's output mux, and out-of-range fetches.

---
 rtl/inst_fetch_if.sv | 22 ++
 rtl/inst_fetch.sv | 123 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect input, decode handshake and fault flag.
interface inst_fetch_if;
  logic [31:0] mem_address;
  logic [15:0] mem_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;

  modport master (
    output mem_address, inst_valid, inst_data, inst_pc, fault,
    input  mem_q, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_address, inst_valid, inst_data, inst_pc, fault,
    output mem_q, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the word PC, issues to a 1-cycle-latency memory and hands
// {instruction, pc} to decode through an output register backed by a one-entry skid buffer.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] MEM_DEPTH = 32'd131072
) (
  input logic          clock,
  input logic          reset_n,
  inst_fetch_if.master bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam logic [AW-1:0] BLOCK0_LAST = AW'(32'h0000_FFFF);

  typedef enum logic {RUN, XBLK} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic          inflight_q, inflight_nxt;
  logic [AW-1:0] inflight_pc_q, inflight_pc_nxt;
  logic          skid_full_q, skid_full_nxt;
  logic [DW-1:0] skid_data_q, skid_data_nxt;
  logic [AW-1:0] skid_pc_q, skid_pc_nxt;
  logic          valid_q, valid_nxt;
  logic [DW-1:0] data_q, data_nxt;
  logic [AW-1:0] pc_q, pc_nxt;
  logic          fault_q, fault_nxt;
  logic          can_load, issue, at_last;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= RUN;
      addr_q        <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_full_q   <= 1'b0;
      skid_data_q   <= '0;
      skid_pc_q     <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      pc_q          <= '0;
      fault_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr_q        <= addr_nxt;
      inflight_q    <= inflight_nxt;
      inflight_pc_q <= inflight_pc_nxt;
      skid_full_q   <= skid_full_nxt;
      skid_data_q   <= skid_data_nxt;
      skid_pc_q     <= skid_pc_nxt;
      valid_q       <= valid_nxt;
      data_q        <= data_nxt;
      pc_q          <= pc_nxt;
      fault_q       <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    addr_nxt        = addr_q;
    inflight_nxt    = 1'b0;
    inflight_pc_nxt = inflight_pc_q;
    skid_full_nxt   = skid_full_q;
    skid_data_nxt   = skid_data_q;
    skid_pc_nxt     = skid_pc_q;
    valid_nxt       = valid_q;
    data_nxt        = data_q;
    pc_nxt          = pc_q;
    fault_nxt       = fault_q;

    can_load = !valid_q || bus.inst_ready;
    at_last  = (33'(addr_q) + 33'd1) >= 33'(MEM_DEPTH);
    issue    = (state == RUN) && !fault_q && !bus.redirect && !skid_full_q && can_load;

    if (bus.redirect) begin
      // In-flight data is discarded, so the block mux never sees a mismatched response.
      addr_nxt      = bus.redirect_pc;
      state_nxt     = RUN;
      fault_nxt     = bus.redirect_pc >= MEM_DEPTH;
      valid_nxt     = 1'b0;
      skid_full_nxt = 1'b0;
    end else begin
      if (skid_full_q && can_load) begin
        valid_nxt     = 1'b1;
        data_nxt      = skid_data_q;
        pc_nxt        = skid_pc_q;
        skid_full_nxt = 1'b0;
      end else if (inflight_q && can_load) begin
        valid_nxt = 1'b1;
        data_nxt  = bus.mem_q;
        pc_nxt    = inflight_pc_q;
      end else if (inflight_q) begin
        skid_full_nxt = 1'b1;
        skid_data_nxt = bus.mem_q;
        skid_pc_nxt   = inflight_pc_q;
      end else if (valid_q && bus.inst_ready) begin
        valid_nxt = 1'b0;
      end

      // Address holds through the crossing cycle so the response comes from the old block.
      if (state == XBLK) begin
        addr_nxt  = addr_q + AW'(1);
        state_nxt = RUN;
      end else if (issue) begin
        inflight_nxt    = 1'b1;
        inflight_pc_nxt = addr_q;
        if (at_last) begin
          fault_nxt = 1'b1;
        end else if (addr_q == BLOCK0_LAST) begin
          state_nxt = XBLK;
        end else begin
          addr_nxt = addr_q + AW'(1);
        end
      end
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.inst_valid  = valid_q;
  assign bus.inst_data   = data_q;
  assign bus.inst_pc     = pc_q;
  assign bus.fault       = fault_q;
endmodule
